// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment driver: hex or sequential shift-add-3 decimal
// display of a latched value, with leading-zero blanking and overflow dashes.
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS    = 4,
   parameter int VALUE_WIDTH   = 16,
   parameter int SCAN_DIV      = 1000,
   parameter int BLANK_LEADING = 1
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic [VALUE_WIDTH-1:0] Value,
   input  logic                   Load,
   input  logic                   DecMode,
   output logic                   Busy,
   output logic                   Overflow,
   output logic [7:0]             SegOut,
   output logic [NUM_DIGITS-1:0]  DigitSel
);

   localparam int DW = 4 * NUM_DIGITS;
   localparam int BW = DW + 4;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int NW = $clog2(VALUE_WIDTH + 1);

   typedef enum logic {IDLE, CONVERT} state_t;

   state_t                 state, state_nxt;
   logic [NW-1:0]          iter;
   logic [VALUE_WIDTH-1:0] shreg;
   logic [BW-1:0]          bcd, bcd_adj, bcd_nxt;
   logic                   sticky;
   logic [DW-1:0]          disp;
   logic                   load_ok, last_iter;
   logic [CW-1:0]          scan_cnt;
   logic [IW-1:0]          idx;
   logic [3:0]             nib;
   logic [DW-1:0]          upper;
   logic                   blank;
   logic [7:0]             seg_cur;

   function automatic logic [7:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 8'h3F;  4'h1: hex7 = 8'h06;  4'h2: hex7 = 8'h5B;  4'h3: hex7 = 8'h4F;
         4'h4: hex7 = 8'h66;  4'h5: hex7 = 8'h6D;  4'h6: hex7 = 8'h7D;  4'h7: hex7 = 8'h07;
         4'h8: hex7 = 8'h7F;  4'h9: hex7 = 8'h6F;  4'hA: hex7 = 8'h77;  4'hB: hex7 = 8'h7C;
         4'hC: hex7 = 8'h39;  4'hD: hex7 = 8'h5E;  4'hE: hex7 = 8'h79;  default: hex7 = 8'h71;
      endcase
   endfunction

   assign Busy      = (state == CONVERT);
   assign load_ok   = Load && (state == IDLE);
   assign last_iter = (state == CONVERT) && (iter == NW'(VALUE_WIDTH - 1));

   // One shift-add-3 step: correct every BCD nibble, then shift in the next value bit
   always_comb begin
      bcd_adj = bcd;
      for (int k = 0; k < BW / 4; k++) begin
         if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
      bcd_nxt = {bcd_adj[BW-2:0], shreg[VALUE_WIDTH-1]};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Load && DecMode) state_nxt = CONVERT;
         CONVERT: if (last_iter)       state_nxt = IDLE;
         default:                      state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state    <= IDLE;
         iter     <= '0;
         sticky   <= 1'b0;
         disp     <= '0;
         Overflow <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load_ok) begin
            iter   <= '0;
            sticky <= 1'b0;
            if (!DecMode) begin
               disp     <= DW'(Value);
               Overflow <= 1'b0;
            end
         end else if (state == CONVERT) begin
            iter   <= iter + 1'b1;
            sticky <= sticky | bcd_adj[BW-1];
            // Display and overflow change together only when the conversion is complete
            if (last_iter) begin
               disp     <= bcd_nxt[DW-1:0];
               Overflow <= sticky | bcd_adj[BW-1] | (|bcd_nxt[BW-1:DW]);
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (load_ok) begin
         shreg <= Value;
         bcd   <= '0;
      end else if (state == CONVERT) begin
         shreg <= shreg << 1;
         bcd   <= bcd_nxt;
      end
   end

   always_comb begin
      nib     = disp[{idx, 2'b00} +: 4];
      upper   = disp >> {idx, 2'b00};
      blank   = (BLANK_LEADING != 0) && (idx != '0) && (upper == '0);
      seg_cur = hex7(nib);
      if (Overflow)   seg_cur = 8'h40;
      else if (blank) seg_cur = 8'h00;
   end

   // Scan stage: outputs follow the digit index and display register by one clock
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         scan_cnt <= '0;
         idx      <= '0;
         SegOut   <= 8'h00;
         DigitSel <= NUM_DIGITS'(1);
      end else begin
         if (scan_cnt == CW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         SegOut   <= seg_cur;
         DigitSel <= NUM_DIGITS'(1) << idx;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: two instances (blanking on/off), table of loads
// with a result scoreboard, plus scan, busy-protection and reset sequences.
module tb_seven_seg_scan_driver;

   logic        clk = 1'b0;
   logic        rst, load, dec_mode;
   logic [15:0] value;
   logic        busy_a, ovf_a, busy_b, ovf_b;
   logic [7:0]  seg_a, seg_b;
   logic [3:0]  sel_a, sel_b;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] value;
      logic        dec;
      logic [31:0] segs;     // digit3..digit0, blanking on
      logic [31:0] segs_nb;  // digit3..digit0, blanking off
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [31:0] segs;
      logic [31:0] segs_nb;
      logic        ovf;
      int          busy;
   } exp_t;

   vec_t vecs[11];
   exp_t sb[$];

   seven_seg_scan_driver #(.NUM_DIGITS(4), .VALUE_WIDTH(16), .SCAN_DIV(4), .BLANK_LEADING(1)) dut_a (
      .Clk(clk), .Rst(rst), .Value(value), .Load(load), .DecMode(dec_mode),
      .Busy(busy_a), .Overflow(ovf_a), .SegOut(seg_a), .DigitSel(sel_a));

   seven_seg_scan_driver #(.NUM_DIGITS(4), .VALUE_WIDTH(16), .SCAN_DIV(4), .BLANK_LEADING(0)) dut_b (
      .Clk(clk), .Rst(rst), .Value(value), .Load(load), .DecMode(dec_mode),
      .Busy(busy_b), .Overflow(ovf_b), .SegOut(seg_b), .DigitSel(sel_b));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int low_bit(input logic [3:0] s);
      for (int i = 0; i < 4; i++) if (s[i]) return i;
      return 0;
   endfunction

   task automatic check_display(input logic [31:0] e, input logic [31:0] enb);
      logic [3:0] seen_a, seen_b;
      int da, db;
      seen_a = 4'h0;
      seen_b = 4'h0;
      @(negedge clk);
      for (int s = 0; s < 16; s++) begin
         da = low_bit(sel_a);
         db = low_bit(sel_b);
         check("digit_a", 32'({sel_a, seg_a}), 32'({4'(1 << da), e[8*da +: 8]}));
         check("digit_b", 32'({sel_b, seg_b}), 32'({4'(1 << db), enb[8*db +: 8]}));
         seen_a[da] = 1'b1;
         seen_b[db] = 1'b1;
         @(negedge clk);
      end
      check("digits_seen_a", 32'(seen_a), 32'hF);
      check("digits_seen_b", 32'(seen_b), 32'hF);
   endtask

   task automatic start(input vec_t v);
      exp_t r;
      @(negedge clk);
      value    = v.value;
      dec_mode = v.dec;
      load     = 1'b1;
      r.segs    = v.segs;
      r.segs_nb = v.segs_nb;
      r.ovf     = v.ovf;
      r.busy    = v.dec ? 16 : 0;
      sb.push_back(r);
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic finish_one(input int pre);
      exp_t r;
      int n;
      n = 0;
      while (busy_a && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL busy_timeout: busy still %0b after %0d cycles", busy_a, n);
      end
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty: got no entry expected one");
         return;
      end
      r = sb.pop_front();
      check("busy_cycles", 32'(n + pre), 32'(r.busy));
      check("busy_b", 32'(busy_b), 32'(0));
      check("overflow_a", 32'(ovf_a), 32'(r.ovf));
      check("overflow_b", 32'(ovf_b), 32'(r.ovf));
      check_display(r.segs, r.segs_nb);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{16'h003D, 1'b0, 32'h00004F5E, 32'h3F3F4F5E, 1'b0};
      vecs[1]  = '{16'd1234, 1'b1, 32'h065B4F66, 32'h065B4F66, 1'b0};
      vecs[2]  = '{16'd10000,1'b1, 32'h40404040, 32'h40404040, 1'b1};
      vecs[3]  = '{16'hFFFF, 1'b0, 32'h71717171, 32'h71717171, 1'b0};
      vecs[4]  = '{16'h0000, 1'b0, 32'h0000003F, 32'h3F3F3F3F, 1'b0};
      vecs[5]  = '{16'd9999, 1'b1, 32'h6F6F6F6F, 32'h6F6F6F6F, 1'b0};
      vecs[6]  = '{16'h0A05, 1'b0, 32'h00773F6D, 32'h3F773F6D, 1'b0};
      vecs[7]  = '{16'd100,  1'b1, 32'h00063F3F, 32'h3F063F3F, 1'b0};
      vecs[8]  = '{16'd0,    1'b1, 32'h0000003F, 32'h3F3F3F3F, 1'b0};
      vecs[9]  = '{16'h1000, 1'b0, 32'h063F3F3F, 32'h063F3F3F, 1'b0};
      vecs[10] = '{16'd65535,1'b1, 32'h40404040, 32'h40404040, 1'b1};

      rst      = 1'b1;
      load     = 1'b0;
      dec_mode = 1'b0;
      value    = 16'h0000;
      #2;
      check("reset_seg", 32'(seg_a), 32'h00);
      check("reset_sel", 32'(sel_a), 32'h1);
      check("reset_busy", 32'(busy_a), 32'h0);
      check("reset_ovf", 32'(ovf_a), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         check("scan_sel", 32'(sel_a), 32'(1 << (((k - 1) / 4) % 4)));
         if (k == 1) begin
            check("first_seg_a", 32'(seg_a), 32'h3F);
            check("first_seg_b", 32'(seg_b), 32'h3F);
         end
      end

      for (int i = 0; i < 11; i++) begin
         start(vecs[i]);
         finish_one(0);
      end

      // Reset in the middle of a conversion, with dashes currently shown
      start('{16'd9999, 1'b1, 32'h6F6F6F6F, 32'h6F6F6F6F, 1'b0});
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy_a), 32'h0);
      check("midrst_ovf", 32'(ovf_a), 32'h0);
      check("midrst_seg", 32'(seg_a), 32'h00);
      check("midrst_sel", 32'(sel_a), 32'h1);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      check_display(32'h0000003F, 32'h3F3F3F3F);
      check("post_rst_busy", 32'(busy_a), 32'h0);

      // Load attempted during conversion must be ignored
      start(vecs[1]);
      repeat (4) @(negedge clk);
      value    = 16'h0009;
      dec_mode = 1'b0;
      load     = 1'b1;
      @(negedge clk);
      load = 1'b0;
      finish_one(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Parametrised, time-multiplexed seven-segment display driver. It is the successor to the two-digit combinational hex decoder. It latches a VALUE_WIDTH-bit value on a load strobe and shows it in hex or decimal across NUM_DIGITS common-select digits. Decimal conversion is sequential (shift-add-3), and the block scans one digit at a time. Leading-zero blanking and decimal overflow indication are included.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8); digit 0 is least significant
VALUE_WIDTH, 16, input value width; must satisfy VALUE_WIDTH <= 4*NUM_DIGITS
SCAN_DIV, 1000, clocks each digit stays selected (>= 2)
BLANK_LEADING, 1, 1 = blank leading zero digits; digit 0 is never blanked

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  asynchronous, active-high reset
Value  input  VALUE_WIDTH  value to display, sampled on accepted Load
Load  input  1  load strobe, sampled on a rising Clk edge
DecMode  input  1  sampled with Load; 0 = hex, 1 = unsigned decimal
Busy  output  1  decimal conversion in progress
Overflow  output  1  decimal value exceeds 10^NUM_DIGITS-1
SegOut  output  8  segments of the selected digit, active-high; bit7 = dp, bits6..0 = g..a
DigitSel  output  NUM_DIGITS  one-hot, active-high digit enable

Behaviour:
- Clock and reset: one clock, Clk. Rst is asynchronous and active-high.
- Reset values:
  - SegOut = 8'h00.
  - DigitSel = one-hot digit 0.
  - Busy = 0, Overflow = 0.
  - Scan counter = 0, digit index = 0.
  - Display register = all nibbles 0, hex mode.
- Segment encoding (dp always 0): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Blank = 00. Dash = 40.
- Load accepted only when Busy = 0. Load while Busy = 1 is ignored and does not disturb the conversion.
- Hex mode, Load accepted at edge E:
  - Display nibbles are loaded from Value at E; nibbles above VALUE_WIDTH are zero-filled.
  - Overflow cleared at E; Busy stays 0.
- Decimal mode, Load accepted at edge E:
  - The FSM moves IDLE -> CONVERT at E. Busy = 1 from E.
  - CONVERT runs exactly VALUE_WIDTH shift iterations, one per clock.
  - At edge E+VALUE_WIDTH the FSM enters IDLE, Busy = 0, and the display register and Overflow update atomically.
  - The BCD accumulator is 4*NUM_DIGITS+4 bits wide. Overflow = 1 if any BCD bit above digit NUM_DIGITS-1 is non-zero.
  - On overflow every digit shows dash (40) and blanking is ignored.
- The old display content is held until the atomic update; no partial results are ever shown.
- Scan:
  - The counter counts 0..SCAN_DIV-1. At terminal count the digit index advances and wraps NUM_DIGITS-1 -> 0.
  - SegOut and DigitSel are registered from the current index and display register, one clock after the index changes.
  - The first post-reset edge shows digit 0 = 3F.
- Blanking (BLANK_LEADING = 1, no overflow): digit k > 0 is blank (00) if it and all higher digits are zero.
- Reset mid-conversion aborts it: FSM returns to IDLE, Busy = 0, display register = 0.
- Simultaneous events: a digit-index advance coinciding with a display update shows the new content on the new digit.

Test Plan:
- Reset: assert Rst mid-run -> SegOut = 00, DigitSel = 0001, Busy = 0, Overflow = 0 immediately; after release, first edge gives digit 0 SegOut = 3F.
- Hex scan (SCAN_DIV = 4): Value = 16'h003D, DecMode = 0 ->
  - digit 0 = 5E, digit 1 = 4F, digits 2 and 3 = 00;
  - DigitSel steps 0001 -> 0010 -> 0100 -> 1000 -> 0001, each held 4 clocks.
- Decimal: Value = 16'd1234, DecMode = 1 -> Busy high exactly 16 clocks; then digits 3..0 = 06, 5B, 4F, 66; Overflow = 0.
- Overflow: Value = 16'd10000, DecMode = 1 -> Overflow = 1, all digits 40; a following hex Load of 16'hFFFF clears Overflow and shows 71 on all four digits.
- Busy protection: Load of 16'h0009 during conversion is ignored and the original result appears. Rst pulse mid-conversion -> Busy = 0, display shows 3F on digit 0, other digits 00.
- Blanking: Value = 0, hex, BLANK_LEADING = 1 -> digit 0 = 3F, others 00; with BLANK_LEADING = 0 -> all digits 3F.
